// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the Si5340-style I2C target.
package i2c_target_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 8;
  localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h74;

  // Bit-9 level on SDA: the target (or master) pulls low to acknowledge.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } r_w_e;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    PTR_HI,
    PTR_HI_ACK,
    PTR_LO,
    PTR_LO_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_e;

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-flop synchronizer, optional glitch filter (macro I2C_FILTER_EN),
// and SCL edge / START / STOP pulse generation. Bit 1 of each vector is SCL, bit 0 is SDA.
module i2c_line_cond #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] meta_q, sync_q, prev_q, line;

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 1");
  end

  // Lines idle high, so reset to 1 to avoid phantom edges after reset release.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
      prev_q <= 2'b11;
    end else begin
      meta_q <= {scl_i, sda_i};
      sync_q <= meta_q;
      prev_q <= line;
    end
  end

`ifdef I2C_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            flt_q, flt_d;

  always_comb begin
    flt_d = flt_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != flt_q[i]) begin
        if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) flt_d[i] = sync_q[i];
        else                                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      flt_q <= 2'b11;
      cnt_q <= '0;
    end else begin
      flt_q <= flt_d;
      cnt_q <= cnt_d;
    end
  end

  assign line = flt_q;
`else
  assign line = sync_q;
`endif

  assign sda_o      = line[0];
  assign scl_rise_o =  line[1] & ~prev_q[1];
  assign scl_fall_o = ~line[1] &  prev_q[1];
  assign start_o    =  line[1] &  prev_q[1] &  prev_q[0] & ~line[0];
  assign stop_o     =  line[1] &  prev_q[1] & ~prev_q[0] &  line[0];

endmodule

// File: rtl/si5340_i2c_target.sv
// I2C target emulating the Si5340 register interface (16-bit pointer, 8-bit data).
// Optional SCL/SDA glitch filter enabled by defining I2C_FILTER_EN.
//   state      | meaning
//   IDLE       | bus free, waiting for START
//   DEV_ADDR   | shifting in device address + R/W
//   DEV_ACK    | driving ACK for matched address
//   PTR_HI/LO  | shifting in pointer high / low byte
//   *_ACK      | driving ACK for the byte just received
//   WR_DATA    | shifting in a write byte
//   RD_DATA    | shifting out reg[pointer]
//   RD_ACK     | sampling master ACK/NACK
//   WAIT_STOP  | not addressed or read ended, ignore until START/STOP
module si5340_i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = SLAVE_ADDR_DEFAULT,
  parameter int unsigned REG_DEPTH  = 256,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oen_o,
  output logic                  wr_strobe_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  input  logic [ADDR_WIDTH-1:0] host_raddr_i,
  output logic [DATA_WIDTH-1:0] host_rdata_o
);

  localparam int unsigned IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  logic sda_s, scl_rise, scl_fall, start_evt, stop_evt;

  i2c_line_cond #(.FILTER_LEN(FILTER_LEN)) u_line_cond (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_evt),
    .stop_o     (stop_evt)
  );

  state_e                state_q;
  logic [3:0]            bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q, rx_byte, rd_byte, wr_data_q, host_rdata_q, host_rdata_d;
  logic [ADDR_WIDTH-1:0] ptr_q, wr_addr_q;
  logic [DATA_WIDTH-1:0] regs_q [REG_DEPTH];
  logic                  sda_oen_q, busy_q, wr_strobe_q;
  logic                  ptr_in_range, host_in_range, byte_done, ack_fall;

  assign rx_byte       = {shift_q[DATA_WIDTH-2:0], sda_s};
  assign ptr_in_range  = {16'h0, ptr_q} < 32'(REG_DEPTH);
  assign host_in_range = {16'h0, host_raddr_i} < 32'(REG_DEPTH);
  assign rd_byte       = ptr_in_range ? regs_q[ptr_q[IDX_W-1:0]] : '0;
  assign byte_done     = scl_rise && (bit_cnt_q == 4'd7);
  assign ack_fall      = scl_fall && (bit_cnt_q == 4'd8);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_oen_q   <= 1'b1;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe_q <= 1'b0;
      if (stop_evt) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        sda_oen_q <= 1'b1;
        bit_cnt_q <= '0;
      end else if (start_evt) begin
        state_q   <= DEV_ADDR;
        sda_oen_q <= 1'b1;
        bit_cnt_q <= '0;
      end else begin
        // Receive states share bit shifting and the ACK drive after bit 8.
        case (state_q)
          DEV_ADDR, PTR_HI, PTR_LO, WR_DATA: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (ack_fall) sda_oen_q <= ACK;
          end
          default: ;
        endcase

        case (state_q)
          DEV_ADDR: begin
            if (byte_done) begin
              if (rx_byte[7:1] == SLAVE_ADDR) busy_q  <= 1'b1;
              else                            state_q <= WAIT_STOP;
            end
            if (ack_fall) state_q <= DEV_ACK;
          end
          DEV_ACK: if (scl_fall) begin
            bit_cnt_q <= '0;
            if (r_w_e'(shift_q[0]) == READ) begin
              state_q   <= RD_DATA;
              shift_q   <= rd_byte;
              sda_oen_q <= rd_byte[7];
            end else begin
              state_q   <= PTR_HI;
              sda_oen_q <= 1'b1;
            end
          end
          PTR_HI: begin
            if (byte_done) ptr_q[15:8] <= rx_byte;
            if (ack_fall)  state_q     <= PTR_HI_ACK;
          end
          PTR_HI_ACK: if (scl_fall) begin
            state_q   <= PTR_LO;
            bit_cnt_q <= '0;
            sda_oen_q <= 1'b1;
          end
          PTR_LO: begin
            if (byte_done) ptr_q[7:0] <= rx_byte;
            if (ack_fall)  state_q    <= PTR_LO_ACK;
          end
          PTR_LO_ACK: if (scl_fall) begin
            state_q   <= WR_DATA;
            bit_cnt_q <= '0;
            sda_oen_q <= 1'b1;
          end
          WR_DATA: begin
            if (byte_done) begin
              wr_strobe_q <= 1'b1;
              wr_addr_q   <= ptr_q;
              wr_data_q   <= rx_byte;
              ptr_q       <= ptr_q + 16'd1;
              if (ptr_in_range) regs_q[ptr_q[IDX_W-1:0]] <= rx_byte;
            end
            if (ack_fall) state_q <= WR_ACK;
          end
          WR_ACK: if (scl_fall) begin
            state_q   <= WR_DATA;
            bit_cnt_q <= '0;
            sda_oen_q <= 1'b1;
          end
          RD_DATA: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) ptr_q <= ptr_q + 16'd1;
            end
            if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                state_q   <= RD_ACK;
                sda_oen_q <= 1'b1;
              end else begin
                shift_q   <= {shift_q[6:0], shift_q[7]};
                sda_oen_q <= shift_q[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && sda_s == NACK) state_q <= WAIT_STOP;
            if (scl_fall) begin
              state_q   <= RD_DATA;
              bit_cnt_q <= '0;
              shift_q   <= rd_byte;
              sda_oen_q <= rd_byte[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Reads the pre-write array contents, so a same-cycle I2C write returns the old value.
  always_comb begin
    host_rdata_d = '0;
    if (host_in_range) host_rdata_d = regs_q[host_raddr_i[IDX_W-1:0]];
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) host_rdata_q <= '0;
    else          host_rdata_q <= host_rdata_d;
  end

  assign sda_oen_o    = sda_oen_q;
  assign wr_strobe_o  = wr_strobe_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = busy_q;
  assign host_rdata_o = host_rdata_q;

endmodule
